// File: rtl/sys_arr_row_feed.sv
// sys_arr_row_feed: collects one batch of stationary weights, issues them in reverse
// order into the leftmost cell of a systolic row, then forwards data words until data_last.
// Ports: clk/rst_n (async active-low), clk_en global enable, in_word/in_rdy upstream
// handshake, sys_arr_data_feed row input, data_cnt words issued this batch,
// err_type sticky wrong-type flag, busy high unless idle with an empty weight buffer.
package sys_arr_pkg;
  localparam int C_SYS_ARR_SIZE = 4;
  localparam int C_DATA_WDT = 16;
  typedef enum logic [1:0] {TYPE_NONE, TYPE_STAT_WEIGHT, TYPE_DATA, TYPE_CTRL} data_type_t;
  typedef struct packed {
    logic                  data_val;
    logic                  data_last;
    data_type_t            data_type;
    logic [C_DATA_WDT-1:0] data;
  } pipe_data_t;
  localparam pipe_data_t C_PIPE_DATA_RST_VAL = '0;
endpackage

module sys_arr_row_feed
  import sys_arr_pkg::*;
#(
  parameter int N_CELLS = C_SYS_ARR_SIZE,
  parameter int CNT_WDT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  pipe_data_t         in_word,
  output logic               in_rdy,
  output pipe_data_t         sys_arr_data_feed,
  output logic [CNT_WDT-1:0] data_cnt,
  output logic               err_type,
  output logic               busy
);
  localparam int PTR_W = N_CELLS > 1 ? $clog2(N_CELLS) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_CELLS - 1);
  typedef enum logic [1:0] {W_COLLECT, W_ISSUE, DATA} state_t;
  state_t                r_state, w_next;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [C_DATA_WDT-1:0] r_buf [N_CELLS];
  pipe_data_t            r_feed;
  logic [CNT_WDT-1:0]    r_cnt;
  logic                  r_err;
  logic                  w_acc, w_wt, w_dat, w_bad, w_issue;
  // Ready is purely a function of state and enable, never of the offered word.
  assign in_rdy  = rst_n & clk_en & (r_state != W_ISSUE);
  assign w_acc   = in_word.data_val & in_rdy;
  assign w_wt    = w_acc & (r_state == W_COLLECT) & (in_word.data_type == TYPE_STAT_WEIGHT);
  assign w_dat   = w_acc & (r_state == DATA) & (in_word.data_type == TYPE_DATA);
  assign w_bad   = w_acc & ~w_wt & ~w_dat;
  assign w_issue = clk_en & (r_state == W_ISSUE);
  assign sys_arr_data_feed = r_feed;
  assign data_cnt = r_cnt;
  assign err_type = r_err;
  assign busy = !(r_state == W_COLLECT && r_wr_ptr == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= W_COLLECT;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_wt && r_wr_ptr == LAST) w_next = W_ISSUE;
    if (w_issue && r_rd_ptr == '0) w_next = DATA;
    if (w_dat && in_word.data_last) w_next = W_COLLECT;
  end
  // Buffer holds only payload; type/valid are regenerated at issue time.
  always_ff @(posedge clk)
    if (w_wt) r_buf[r_wr_ptr] <= in_word.data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_feed   <= C_PIPE_DATA_RST_VAL;
    end else if (clk_en) begin
      r_feed <= C_PIPE_DATA_RST_VAL;
      if (w_wt) begin
        r_wr_ptr <= r_wr_ptr == LAST ? '0 : r_wr_ptr + 1'b1;
        if (r_wr_ptr == LAST) r_rd_ptr <= LAST;
        if (r_wr_ptr == '0) r_cnt <= '0;
      end
      // Reverse order: column N_CELLS-1 must see its weight first as it travels furthest.
      if (w_issue) begin
        r_feed   <= '{data_val: 1'b1, data_last: 1'b0, data_type: TYPE_STAT_WEIGHT, data: r_buf[r_rd_ptr]};
        r_rd_ptr <= r_rd_ptr - 1'b1;
      end
      if (w_dat) begin
        r_feed <= in_word;
        r_cnt  <= &r_cnt ? r_cnt : r_cnt + 1'b1;
      end
      if (w_bad) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_sys_arr_row_feed.sv
// tb_sys_arr_row_feed: directed self-checking bench for sys_arr_row_feed with N_CELLS=4.
module tb_sys_arr_row_feed;
  import sys_arr_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  pipe_data_t  in_word = '0;
  logic        in_rdy;
  pipe_data_t  feed;
  logic [15:0] data_cnt;
  logic        err_type;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  sys_arr_row_feed #(.N_CELLS(4), .CNT_WDT(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_word(in_word), .in_rdy(in_rdy),
    .sys_arr_data_feed(feed), .data_cnt(data_cnt), .err_type(err_type), .busy(busy)
  );
  function automatic pipe_data_t wd(data_type_t t, logic l, logic [15:0] d);
    return '{data_val: 1'b1, data_last: l, data_type: t, data: d};
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_feed(string tag, pipe_data_t exp);
    check(tag, 32'(feed), 32'(exp));
  endtask
  initial begin
    #3;
    check("rst_rdy", 32'(in_rdy), 0);
    chk_feed("rst_feed", C_PIPE_DATA_RST_VAL);
    check("rst_cnt", 32'(data_cnt), 0);
    check("rst_err", 32'(err_type), 0);
    check("rst_busy", 32'(busy), 0);
    #9 rst_n = 1'b1;
    #1 check("rdy_collect", 32'(in_rdy), 1);
    for (int i = 1; i <= 4; i++) begin
      in_word = wd(TYPE_STAT_WEIGHT, 1'b0, 16'(i));
      step();
      if (i == 1) check("busy_w1", 32'(busy), 1);
    end
    in_word = '0;
    chk_feed("feed_pre_issue", C_PIPE_DATA_RST_VAL);
    for (int i = 0; i < 4; i++) begin
      check("rdy_issue", 32'(in_rdy), 0);
      step();
      chk_feed("issue_a", wd(TYPE_STAT_WEIGHT, 1'b0, 16'(4 - i)));
    end
    check("rdy_data", 32'(in_rdy), 1);
    for (int i = 0; i < 3; i++) begin
      in_word = wd(TYPE_DATA, i == 2, 16'(10 + i));
      step();
      chk_feed("data_a", wd(TYPE_DATA, i == 2, 16'(10 + i)));
      check("cnt_a", 32'(data_cnt), 32'(i + 1));
    end
    in_word = '0;
    check("rdy_back", 32'(in_rdy), 1);
    check("busy_idle", 32'(busy), 0);
    step();
    chk_feed("feed_idle", C_PIPE_DATA_RST_VAL);
    check("cnt_hold", 32'(data_cnt), 3);
    in_word = wd(TYPE_STAT_WEIGHT, 1'b0, 16'd21);
    step();
    check("cnt_clr", 32'(data_cnt), 0);
    in_word = wd(TYPE_STAT_WEIGHT, 1'b0, 16'd22);
    step();
    in_word = wd(TYPE_DATA, 1'b0, 16'd99);
    step();
    check("err_set", 32'(err_type), 1);
    chk_feed("err_feed", C_PIPE_DATA_RST_VAL);
    check("err_busy", 32'(busy), 1);
    in_word = wd(TYPE_STAT_WEIGHT, 1'b0, 16'd23);
    step();
    in_word = wd(TYPE_STAT_WEIGHT, 1'b0, 16'd24);
    step();
    in_word = '0;
    step();
    chk_feed("issue_b0", wd(TYPE_STAT_WEIGHT, 1'b0, 16'd24));
    step();
    chk_feed("issue_b1", wd(TYPE_STAT_WEIGHT, 1'b0, 16'd23));
    clk_en = 1'b0;
    repeat (3) begin
      step();
      chk_feed("stall_feed", wd(TYPE_STAT_WEIGHT, 1'b0, 16'd23));
      check("stall_rdy", 32'(in_rdy), 0);
    end
    clk_en = 1'b1;
    step();
    chk_feed("issue_b2", wd(TYPE_STAT_WEIGHT, 1'b0, 16'd22));
    step();
    chk_feed("issue_b3", wd(TYPE_STAT_WEIGHT, 1'b0, 16'd21));
    for (int i = 0; i < 5; i++) begin
      in_word = i % 2 ? pipe_data_t'('0) : wd(TYPE_DATA, i == 4, 16'(30 + i / 2));
      step();
      chk_feed("bubble_feed", i % 2 ? C_PIPE_DATA_RST_VAL : wd(TYPE_DATA, i == 4, 16'(30 + i / 2)));
      check("bubble_cnt", 32'(data_cnt), 32'(i / 2 + 1));
    end
    check("err_sticky", 32'(err_type), 1);
    for (int i = 41; i <= 44; i++) begin
      in_word = wd(TYPE_STAT_WEIGHT, 1'b0, 16'(i));
      step();
    end
    in_word = '0;
    repeat (4) step();
    chk_feed("issue_c3", wd(TYPE_STAT_WEIGHT, 1'b0, 16'd41));
    in_word = wd(TYPE_DATA, 1'b0, 16'd50);
    step();
    in_word = wd(TYPE_DATA, 1'b0, 16'd51);
    #1 rst_n = 1'b0;
    #1;
    chk_feed("arst_feed", C_PIPE_DATA_RST_VAL);
    check("arst_rdy", 32'(in_rdy), 0);
    check("arst_cnt", 32'(data_cnt), 0);
    check("arst_err", 32'(err_type), 0);
    #1 rst_n = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      in_word = wd(TYPE_STAT_WEIGHT, 1'b0, 16'(i));
      step();
    end
    in_word = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_feed("issue_d", wd(TYPE_STAT_WEIGHT, 1'b0, 16'(8 - i)));
    end
    in_word = wd(TYPE_STAT_WEIGHT, 1'b0, 16'd77);
    step();
    check("err_data", 32'(err_type), 1);
    chk_feed("err_data_feed", C_PIPE_DATA_RST_VAL);
    check("err_data_cnt", 32'(data_cnt), 0);
    in_word = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sys_arr_row_feed.md
SYS_ARR_ROW_FEED -- requirements
Module: sys_arr_row_feed

Interface
REQ-001 SHALL have parameter N_CELLS, default C_SYS_ARR_SIZE: number of cells in the driven systolic row.
REQ-002 SHALL have parameter CNT_WDT, default 16: width of the data-word counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port clk_en, input, 1: global clock enable.
REQ-006 SHALL have port in_word, input, pipe_data_t: upstream word; data_val is its valid flag.
REQ-007 SHALL have port in_rdy, output, 1: upstream ready; a word is accepted when in_word.data_val & in_rdy & clk_en.
REQ-008 SHALL have port sys_arr_data_feed, output, pipe_data_t: word driven into the leftmost cell of the row.
REQ-009 SHALL have port data_cnt, output, CNT_WDT: number of data words issued in the current batch.
REQ-010 SHALL have port err_type, output, 1: sticky flag for a wrong-type word.
REQ-011 SHALL have port busy, output, 1: high in every state except W_COLLECT with zero weights buffered.

Function
REQ-012 SHALL implement the states W_COLLECT, W_ISSUE and DATA.
REQ-013 In W_COLLECT, in_rdy SHALL be 1, and each accepted TYPE_STAT_WEIGHT word SHALL be stored in buffer slot wr_ptr, with wr_ptr incrementing from 0.
REQ-014 When the N_CELLS-th weight is accepted, the block SHALL enter W_ISSUE on the next cycle with rd_ptr = N_CELLS-1.
REQ-015 In W_ISSUE, in_rdy SHALL be 0.
REQ-016 In W_ISSUE, each enabled cycle SHALL register buffer[rd_ptr] onto sys_arr_data_feed with data_type = TYPE_STAT_WEIGHT, data_val = 1 and data_last = 0, then decrement rd_ptr.
REQ-017 Weights SHALL leave in reverse order (column N_CELLS-1 first), because a cell at column c captures the (N_CELLS-c)-th weight that reaches it.
REQ-018 After the cycle that issues rd_ptr = 0, the block SHALL enter DATA.
REQ-019 In DATA, in_rdy SHALL be 1.
REQ-020 In DATA, an accepted TYPE_DATA word SHALL appear unchanged on sys_arr_data_feed exactly 1 enabled cycle later, and data_cnt SHALL increment, saturating at all-ones.
REQ-021 In DATA, every cycle with no accepted word SHALL drive C_PIPE_DATA_RST_VAL on the output.
REQ-022 An accepted data word with data_last = 1 SHALL be forwarded with data_last = 1, and the block SHALL return to W_COLLECT with wr_ptr = 0.
REQ-023 data_cnt SHALL clear on the first weight accepted in the following W_COLLECT.
REQ-024 The first weight of the next batch MAY be accepted in the cycle directly after the last data word.
REQ-025 A word whose type is wrong for the state (non-weight in W_COLLECT, non-data in DATA) SHALL be accepted and dropped, SHALL set err_type, and SHALL NOT alter the pointers or the output.
REQ-026 Only a reset SHALL clear err_type.
REQ-027 In W_COLLECT and in all non-issue cycles, sys_arr_data_feed SHALL equal C_PIPE_DATA_RST_VAL.
REQ-028 While clk_en = 0, in_rdy SHALL be 0, and the state, pointers, buffer, counters and sys_arr_data_feed SHALL hold.
REQ-029 in_rdy SHALL depend only on the state and clk_en, never on in_word.
REQ-030 Upstream bubbles during W_COLLECT SHALL only stretch collection, and during DATA SHALL produce invalid output words; neither case SHALL be an error.

Reset
REQ-031 On rst_n = 0, asynchronously: state SHALL become W_COLLECT, wr_ptr SHALL be 0, rd_ptr SHALL be 0, data_cnt SHALL be 0, err_type SHALL be 0 and sys_arr_data_feed SHALL be C_PIPE_DATA_RST_VAL.
REQ-032 On rst_n = 0, in_rdy SHALL be 0 while rst_n is low; buffer contents need not be cleared.
REQ-033 Reset asserted mid-W_ISSUE or mid-DATA SHALL abandon the batch, and the next accepted word SHALL be treated as weight 0 of a new batch.

Verification
REQ-034 N_CELLS=4, weights 1,2,3,4 accepted back-to-back -> output shows 4,3,2,1 on 4 consecutive cycles, type STAT_WEIGHT; in_rdy is 0 for those 4 cycles.
REQ-035 Then data 10,11,12 with last on 12 -> each is output 1 cycle after acceptance, data_last only on 12, data_cnt ends at 3, and in_rdy stays high into W_COLLECT.
REQ-036 A TYPE_DATA word offered in W_COLLECT after 2 weights -> err_type = 1, wr_ptr stays 2, output stays C_PIPE_DATA_RST_VAL, and the batch completes normally after 2 more weights.
REQ-037 clk_en low for 3 cycles after the 2nd issued weight -> output holds weight 3 and in_rdy is 0; on resume, weights 2,1 follow and no weight is lost or duplicated.
REQ-038 rst_n pulsed low during the 2nd data word -> output goes invalid immediately; the next words 5,6,7,8 are buffered as weights and issued as 8,7,6,5.
REQ-039 Data with an upstream bubble every other cycle -> the output alternates valid word / C_PIPE_DATA_RST_VAL, and data_cnt counts only the valid words.
